// File: rtl/seg7_pkg.sv
// Shared types and constants for the seven-segment scan path.
// Glyph table is stored active-high; seg_polarity() maps it to the board polarity.
package seg7_pkg;

    typedef enum logic {
        BLANK,
        SHOW
    } scan_state_e;

    // Bit order {g,f,e,d,c,b,a}, 1 = segment lit.
    localparam logic [6:0] SEG7_HEX [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
    };

    function automatic logic [6:0] seg_polarity(input logic [6:0] segs_hi,
                                                input logic       active_low);
        return active_low ? ~segs_hi : segs_hi;
    endfunction

endpackage

// File: rtl/hex_to_seg7.sv
// Combinational hex nibble to active-high seven-segment glyph.
module hex_to_seg7
    import seg7_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] seg_hi
);

    always_comb begin
        seg_hi = SEG7_HEX[nibble];
    end

endmodule

// File: rtl/seven_seg_scan_mux.sv
// Time-multiplexed NUM_DIGITS seven-segment driver with frame-coherent shadow data
// and inter-digit blanking. Optional macro LEADING_ZERO_BLANK_EN blanks leading zeros.
module seven_seg_scan_mux
    import seg7_pkg::*;
#(
    parameter int unsigned NUM_DIGITS     = 8,
    parameter int unsigned REFRESH_DIV    = 100000,
    parameter int unsigned BLANK_CYCLES   = 1000,
    parameter logic        SEG_ACTIVE_LOW = 1'b1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [4*NUM_DIGITS-1:0]   data_in,
    input  logic                      load,
    input  logic [NUM_DIGITS-1:0]     dp_in,
    output logic [6:0]                seg,
    output logic                      dp,
    output logic [NUM_DIGITS-1:0]     an,
    output logic                      frame_done
);

    localparam int unsigned DW    = 4 * NUM_DIGITS;
    localparam int unsigned IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int unsigned MAXC  = (REFRESH_DIV > BLANK_CYCLES) ? REFRESH_DIV : BLANK_CYCLES;
    localparam int unsigned PRE_W = $clog2(MAXC);

    localparam logic [PRE_W-1:0]      BLANK_LAST = PRE_W'(BLANK_CYCLES - 1);
    localparam logic [PRE_W-1:0]      SHOW_LAST  = PRE_W'(REFRESH_DIV - 1);
    localparam logic [IDX_W-1:0]      IDX_LAST   = IDX_W'(NUM_DIGITS - 1);
    localparam logic [6:0]            SEG_OFF    = seg_polarity(7'h00, SEG_ACTIVE_LOW);
    localparam logic                  DP_OFF     = SEG_ACTIVE_LOW;
    localparam logic [NUM_DIGITS-1:0] AN_OFF     = {NUM_DIGITS{SEG_ACTIVE_LOW}};

    scan_state_e            state_q, state_d;
    logic [PRE_W-1:0]       presc_q, presc_d;
    logic [IDX_W-1:0]       idx_q, idx_d;
    logic [DW-1:0]          pend_data_q, pend_data_d;
    logic [NUM_DIGITS-1:0]  pend_dp_q, pend_dp_d;
    logic [DW-1:0]          shadow_data_q, shadow_data_d;
    logic [NUM_DIGITS-1:0]  shadow_dp_q, shadow_dp_d;
    logic [6:0]             seg_q, seg_d;
    logic                   dp_q, dp_d;
    logic [NUM_DIGITS-1:0]  an_q, an_d;
    logic                   frame_end;
    logic [3:0]             cur_nibble;
    logic [6:0]             cur_seg_hi;
    logic                   digit_blank;

    always_comb begin
        state_d   = state_q;
        presc_d   = presc_q + PRE_W'(1);
        idx_d     = idx_q;
        frame_end = 1'b0;
        unique case (state_q)
            BLANK: begin
                if (presc_q == BLANK_LAST) begin
                    state_d = SHOW;
                    presc_d = '0;
                end
            end
            SHOW: begin
                if (presc_q == SHOW_LAST) begin
                    state_d   = BLANK;
                    presc_d   = '0;
                    frame_end = (idx_q == IDX_LAST);
                    idx_d     = (idx_q == IDX_LAST) ? '0 : idx_q + IDX_W'(1);
                end
            end
            default: begin
                state_d = BLANK;
                presc_d = '0;
            end
        endcase
    end

    // pend_*_d already folds in a coincident load, so frame end picks up fresh data directly.
    always_comb begin
        pend_data_d   = load ? data_in : pend_data_q;
        pend_dp_d     = load ? dp_in   : pend_dp_q;
        shadow_data_d = frame_end ? pend_data_d : shadow_data_q;
        shadow_dp_d   = frame_end ? pend_dp_d   : shadow_dp_q;
    end

`ifdef LEADING_ZERO_BLANK_EN
    logic [NUM_DIGITS-1:0] blank_q, blank_d;

    // Digits above the most-significant non-zero nibble; digit 0 is never blanked.
    function automatic logic [NUM_DIGITS-1:0] lz_mask(input logic [DW-1:0] v);
        logic [NUM_DIGITS-1:0] m;
        logic                  seen;
        m    = '0;
        seen = 1'b0;
        for (int unsigned i = NUM_DIGITS - 1; i >= 1; i--) begin
            seen = seen | (v[4*i +: 4] != 4'h0);
            m[i] = ~seen;
        end
        return m;
    endfunction

    always_comb begin
        blank_d     = frame_end ? lz_mask(shadow_data_d) : blank_q;
        digit_blank = blank_q[idx_q];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            blank_q <= ~NUM_DIGITS'(1);
        end else begin
            blank_q <= blank_d;
        end
    end
`else
    always_comb begin
        digit_blank = 1'b0;
    end
`endif

    always_comb begin
        cur_nibble = shadow_data_q[{idx_q, 2'b00} +: 4];
    end

    hex_to_seg7 u_dec (
        .nibble (cur_nibble),
        .seg_hi (cur_seg_hi)
    );

    always_comb begin
        seg_d = SEG_OFF;
        dp_d  = DP_OFF;
        an_d  = AN_OFF;
        if (state_q == SHOW) begin
            seg_d = seg_polarity(digit_blank ? 7'h00 : cur_seg_hi, SEG_ACTIVE_LOW);
            dp_d  = shadow_dp_q[idx_q] ^ SEG_ACTIVE_LOW;
            an_d  = (NUM_DIGITS'(1) << idx_q) ^ AN_OFF;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= BLANK;
            presc_q       <= '0;
            idx_q         <= '0;
            pend_data_q   <= '0;
            pend_dp_q     <= '0;
            shadow_data_q <= '0;
            shadow_dp_q   <= '0;
            seg_q         <= SEG_OFF;
            dp_q          <= DP_OFF;
            an_q          <= AN_OFF;
        end else begin
            state_q       <= state_d;
            presc_q       <= presc_d;
            idx_q         <= idx_d;
            pend_data_q   <= pend_data_d;
            pend_dp_q     <= pend_dp_d;
            shadow_data_q <= shadow_data_d;
            shadow_dp_q   <= shadow_dp_d;
            seg_q         <= seg_d;
            dp_q          <= dp_d;
            an_q          <= an_d;
        end
    end

    assign seg        = seg_q;
    assign dp         = dp_q;
    assign an         = an_q;
    assign frame_done = frame_end;

endmodule
